// File: rtl/blackjack_pkg.sv
// Shared definitions for the blackjack table: FSM state codes, result codes and
// card/settlement helpers used by the hand accumulators and the table controller.
package blackjack_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE            = 4'd0;
    localparam state_t S_DEAL            = 4'd1;
    localparam state_t S_DEAL_WAIT       = 4'd2;
    localparam state_t S_CHECK_DEALER_BJ = 4'd3;
    localparam state_t S_PLAYER_TURN     = 4'd4;
    localparam state_t S_PLAYER_WAIT     = 4'd5;
    localparam state_t S_NEXT_SEAT       = 4'd6;
    localparam state_t S_DEALER_TURN     = 4'd7;
    localparam state_t S_DEALER_WAIT     = 4'd8;
    localparam state_t S_SETTLE          = 4'd9;
    localparam state_t S_DONE            = 4'd10;

    typedef enum logic [2:0] {
        RES_NONE      = 3'd0,
        RES_WIN       = 3'd1,
        RES_LOSE      = 3'd2,
        RES_TIE       = 3'd3,
        RES_BLACKJACK = 3'd4,
        RES_CHARLIE   = 3'd5
    } result_e;

    // Ace counts as 1 here; out-of-range ranks are treated like a ten-card.
    function automatic logic [3:0] card_value(input logic [3:0] rank);
        logic [3:0] v;
        if (rank == 4'd0 || rank > 4'd10) begin
            v = 4'd10;
        end else begin
            v = rank;
        end
        return v;
    endfunction

    function automatic logic [4:0] sat5(input logic [5:0] v);
        return (v > 6'd31) ? 5'd31 : v[4:0];
    endfunction

    function automatic result_e settle_seat(
        input logic [5:0] s_best, input logic s_bust, input logic s_bj, input logic s_charlie,
        input logic [5:0] d_best, input logic d_bust, input logic d_bj, input logic d_charlie
    );
        result_e r;
        if (s_bust)            r = RES_LOSE;
        else if (d_bj)         r = s_bj ? RES_TIE : RES_LOSE;
        else if (s_bj)         r = RES_BLACKJACK;
        else if (s_charlie)    r = RES_CHARLIE;
        else if (d_charlie)    r = RES_LOSE;
        else if (d_bust)       r = RES_WIN;
        else if (s_best > d_best) r = RES_WIN;
        else if (s_best < d_best) r = RES_LOSE;
        else                   r = RES_TIE;
        return r;
    endfunction

endpackage

// File: rtl/blackjack_table_hand.sv
// One blackjack hand: saturating hard sum, ace flag and card count, with the
// derived best/soft/bust/blackjack views.
module hand_accumulator
    import blackjack_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_clear,
    input  logic       i_add,
    input  logic [3:0] i_rank,
    output logic [5:0] o_best,
    output logic       o_soft,
    output logic       o_bust,
    output logic       o_blackjack,
    output logic [2:0] o_count
);

    logic [5:0] r_hard;
    logic       r_ace;
    logic [2:0] r_count;
    logic [6:0] w_hardNext;

    assign w_hardNext = {1'b0, r_hard} + {3'b000, card_value(i_rank)};

    // Hand state: cleared at round start, one card folded in per add strobe.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_hard  <= 6'd0;
            r_ace   <= 1'b0;
            r_count <= 3'd0;
        end else if (i_add) begin
            r_hard  <= (w_hardNext > 7'd63) ? 6'd63 : w_hardNext[5:0];
            r_ace   <= r_ace | (i_rank == 4'd1);
            r_count <= (r_count == 3'd7) ? 3'd7 : r_count + 3'd1;
        end
    end

    // Derived hand views; one ace is promoted to 11 when it cannot bust the hand.
    always_comb begin
        o_soft = r_ace && (r_hard <= 6'd11);
        if (o_soft) begin
            o_best = r_hard + 6'd10;
        end else begin
            o_best = r_hard;
        end
        o_bust      = (o_best > 6'd21);
        o_blackjack = (r_count == 3'd2) && (o_best == 6'd21);
        o_count     = r_count;
    end

endmodule

// File: rtl/blackjack_table.sv
// Multi-seat blackjack round controller: deals, runs seat turns and the dealer
// turn, then settles every seat. Optional macro: DEALER_HITS_SOFT17_EN.
module blackjack_table
    import blackjack_pkg::*;
#(
    parameter int NUM_PLAYERS  = 2,
    parameter int MAX_CARDS    = 5,
    parameter int DEALER_STAND = 17,
    parameter int SEAT_W       = $clog2(NUM_PLAYERS + 1)
)(
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_newRound,
    input  logic                     i_hit,
    input  logic                     i_stand,
    output logic                     o_cardReq,
    input  logic                     i_cardValid,
    input  logic [3:0]               i_cardRank,
    output logic [SEAT_W-1:0]        o_activeSeat,
    output logic [3:0]               o_gameState,
    output logic [NUM_PLAYERS*5-1:0] o_seatSum,
    output logic [4:0]               o_dealerSum,
    output logic [NUM_PLAYERS*3-1:0] o_seatResult,
    output logic                     o_roundDone
);

    localparam int NUM_HANDS = NUM_PLAYERS + 1;
    localparam logic [SEAT_W-1:0] DEALER_IDX = SEAT_W'(NUM_PLAYERS);
    localparam logic [SEAT_W-1:0] LAST_SEAT  = SEAT_W'(NUM_PLAYERS - 1);

    logic [3:0]               r_state;
    logic [SEAT_W-1:0]        r_seat;
    logic                     r_pass;
    logic                     r_cardReq;
    logic [NUM_PLAYERS*3-1:0] r_result;
    logic [NUM_PLAYERS*5-1:0] r_seatSum;
    logic [4:0]               r_dealerSum;

    logic [5:0]               w_best  [NUM_HANDS];
    logic [2:0]               w_count [NUM_HANDS];
    logic [NUM_HANDS-1:0]     w_soft, w_bust, w_bj, w_charlie, w_add;
    logic [NUM_PLAYERS*3-1:0] w_settle;
    logic                     w_clear, w_capture, w_seatDone, w_allBust;
    logic                     w_dealerWants, w_dealerDraw, w_dealerShown, w_unusedSoft;

    assign w_clear   = i_newRound && (r_state == S_IDLE || r_state == S_DONE);
    assign w_capture = r_cardReq && i_cardValid;

    for (genvar h = 0; h < NUM_HANDS; h++) begin : g_hand
        hand_accumulator u_hand (
            .i_clk       (i_clk),
            .i_reset     (i_reset),
            .i_clear     (w_clear),
            .i_add       (w_add[h]),
            .i_rank      (i_cardRank),
            .o_best      (w_best[h]),
            .o_soft      (w_soft[h]),
            .o_bust      (w_bust[h]),
            .o_blackjack (w_bj[h]),
            .o_count     (w_count[h])
        );
        assign w_charlie[h] = (w_count[h] == 3'(MAX_CARDS)) && !w_bust[h];
    end

    assign w_unusedSoft = &{1'b0, w_soft};

    // Route a captured card to whichever hand the seat pointer names.
    always_comb begin
        w_add = '0;
        for (int h = 0; h < NUM_HANDS; h++) begin
            w_add[h] = w_capture && (r_seat == SEAT_W'(h));
        end
    end

    assign w_seatDone = w_bust[r_seat] || (w_best[r_seat] == 6'd21) ||
                        (w_count[r_seat] == 3'(MAX_CARDS));
    assign w_allBust  = &w_bust[NUM_PLAYERS-1:0];

`ifdef DEALER_HITS_SOFT17_EN
    assign w_dealerWants = (w_best[NUM_PLAYERS] < 6'(DEALER_STAND)) ||
                           ((w_best[NUM_PLAYERS] == 6'd17) && w_soft[NUM_PLAYERS]);
`else
    assign w_dealerWants = (w_best[NUM_PLAYERS] < 6'(DEALER_STAND));
`endif
    assign w_dealerDraw  = w_dealerWants && (w_count[NUM_PLAYERS] < 3'(MAX_CARDS));
    assign w_dealerShown = (r_state == S_DEALER_TURN) || (r_state == S_DEALER_WAIT) ||
                           (r_state == S_SETTLE) || (r_state == S_DONE);

    // Per-seat settlement against the dealer hand.
    always_comb begin
        w_settle = '0;
        for (int s = 0; s < NUM_PLAYERS; s++) begin
            w_settle[s*3 +: 3] = settle_seat(w_best[s], w_bust[s], w_bj[s], w_charlie[s],
                                             w_best[NUM_PLAYERS], w_bust[NUM_PLAYERS],
                                             w_bj[NUM_PLAYERS], w_charlie[NUM_PLAYERS]);
        end
    end

    // Round sequencer, card request handshake and result latching.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_seat    <= '0;
            r_pass    <= 1'b0;
            r_cardReq <= 1'b0;
            r_result  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_newRound) begin
                        r_state  <= S_DEAL;
                        r_seat   <= '0;
                        r_pass   <= 1'b0;
                        r_result <= '0;
                    end
                end
                S_DEAL: begin
                    r_cardReq <= 1'b1;
                    r_state   <= S_DEAL_WAIT;
                end
                S_DEAL_WAIT: begin
                    if (w_capture) begin
                        r_cardReq <= 1'b0;
                        if (r_seat != DEALER_IDX) begin
                            r_seat  <= r_seat + SEAT_W'(1);
                            r_state <= S_DEAL;
                        end else if (r_pass) begin
                            r_state <= S_CHECK_DEALER_BJ;
                        end else begin
                            r_seat  <= '0;
                            r_pass  <= 1'b1;
                            r_state <= S_DEAL;
                        end
                    end
                end
                S_CHECK_DEALER_BJ: begin
                    if (w_bj[NUM_PLAYERS]) begin
                        r_state <= S_SETTLE;
                    end else begin
                        r_seat  <= '0;
                        r_state <= S_PLAYER_TURN;
                    end
                end
                S_PLAYER_TURN: begin
                    if (w_seatDone || i_stand) begin
                        r_state <= S_NEXT_SEAT;
                    end else if (i_hit) begin
                        r_cardReq <= 1'b1;
                        r_state   <= S_PLAYER_WAIT;
                    end
                end
                S_PLAYER_WAIT: begin
                    if (w_capture) begin
                        r_cardReq <= 1'b0;
                        r_state   <= S_PLAYER_TURN;
                    end
                end
                S_NEXT_SEAT: begin
                    if (r_seat == LAST_SEAT) begin
                        r_seat  <= DEALER_IDX;
                        r_state <= S_DEALER_TURN;
                    end else begin
                        r_seat  <= r_seat + SEAT_W'(1);
                        r_state <= S_PLAYER_TURN;
                    end
                end
                S_DEALER_TURN: begin
                    if (w_allBust || !w_dealerDraw) begin
                        r_state <= S_SETTLE;
                    end else begin
                        r_cardReq <= 1'b1;
                        r_state   <= S_DEALER_WAIT;
                    end
                end
                S_DEALER_WAIT: begin
                    if (w_capture) begin
                        r_cardReq <= 1'b0;
                        r_state   <= S_DEALER_TURN;
                    end
                end
                S_SETTLE: begin
                    r_result <= w_settle;
                    r_state  <= S_DONE;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_cardReq <= 1'b0;
                end
            endcase
        end
    end

    // Displayed sums; the dealer total stays hidden until the dealer plays.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_seatSum   <= '0;
            r_dealerSum <= 5'd0;
        end else begin
            for (int s = 0; s < NUM_PLAYERS; s++) begin
                r_seatSum[s*5 +: 5] <= sat5(w_best[s]);
            end
            r_dealerSum <= w_dealerShown ? sat5(w_best[NUM_PLAYERS]) : 5'd0;
        end
    end

    assign o_cardReq    = r_cardReq;
    assign o_activeSeat = r_seat;
    assign o_gameState  = r_state;
    assign o_seatSum    = r_seatSum;
    assign o_dealerSum  = r_dealerSum;
    assign o_seatResult = r_result;
    assign o_roundDone  = (r_state == S_DONE);

endmodule

// File: tb/tb_blackjack_table.sv
// Directed bench for blackjack_table with a deck model and a result scoreboard.
module tb_blackjack_table;
    import blackjack_pkg::*;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_newRound = 1'b0;
    logic       i_hit = 1'b0;
    logic       i_stand = 1'b0;
    logic       o_cardReq;
    logic       i_cardValid = 1'b0;
    logic [3:0] i_cardRank = 4'd0;
    logic [1:0] o_activeSeat;
    logic [3:0] o_gameState;
    logic [9:0] o_seatSum;
    logic [4:0] o_dealerSum;
    logic [5:0] o_seatResult;
    logic       o_roundDone;

    int vectors = 0;
    int miscompares = 0;
    int deck[$];
    int served = 0;
    int stall_left = 0;

    typedef struct { string tag; int r0; int r1; } exp_t;
    exp_t sb[$];

    blackjack_table #(.NUM_PLAYERS(2), .MAX_CARDS(5), .DEALER_STAND(17)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_newRound(i_newRound), .i_hit(i_hit),
        .i_stand(i_stand), .o_cardReq(o_cardReq), .i_cardValid(i_cardValid),
        .i_cardRank(i_cardRank), .o_activeSeat(o_activeSeat), .o_gameState(o_gameState),
        .o_seatSum(o_seatSum), .o_dealerSum(o_dealerSum), .o_seatResult(o_seatResult),
        .o_roundDone(o_roundDone)
    );

    always #5 i_clk = ~i_clk;

    // Deck model: answers each request with the next queued card, optionally after a stall.
    initial begin
        forever begin
            @(negedge i_clk);
            if (o_cardReq && !i_reset) begin
                if (stall_left > 0) begin
                    stall_left--;
                    i_cardValid = 1'b0;
                end else if (deck.size() > 0) begin
                    i_cardRank  = 4'(deck.pop_front());
                    i_cardValid = 1'b1;
                    served++;
                end else begin
                    i_cardValid = 1'b0;
                end
            end else begin
                i_cardValid = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [3:0] st, input int seat, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge i_clk);
            if (o_gameState == st && 32'(o_activeSeat) == seat) found = 1'b1;
        end
        check({tag, " reached"}, 32'(found), 32'd1);
    endtask

    task automatic start_round(input string tag, input int r0, input int r1);
        exp_t e;
        e.tag = tag; e.r0 = r0; e.r1 = r1;
        sb.push_back(e);
        @(negedge i_clk);
        i_newRound = 1'b1;
        @(negedge i_clk);
        i_newRound = 1'b0;
    endtask

    task automatic pulse_hit();
        i_hit = 1'b1;
        @(negedge i_clk);
        i_hit = 1'b0;
    endtask

    task automatic pulse_stand();
        i_stand = 1'b1;
        @(negedge i_clk);
        i_stand = 1'b0;
    endtask

    task automatic wait_done(output bit req_seen);
        bit found = 1'b0;
        exp_t e;
        req_seen = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge i_clk);
            if (o_cardReq) req_seen = 1'b1;
            if (o_roundDone) found = 1'b1;
        end
        check("round done", 32'(found), 32'd1);
        check("scoreboard entry", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, " seat0 result"}, 32'(o_seatResult[2:0]), 32'(e.r0));
            check({e.tag, " seat1 result"}, 32'(o_seatResult[5:3]), 32'(e.r1));
        end
    endtask

    initial begin
        bit req_seen;
        int held;

        repeat (3) @(negedge i_clk);
        check("rst state", 32'(o_gameState), 32'(S_IDLE));
        check("rst req", 32'(o_cardReq), 32'd0);
        check("rst sums", 32'({o_seatSum, o_dealerSum}), 32'd0);
        check("rst results", 32'({o_seatResult, o_roundDone, o_activeSeat}), 32'd0);
        i_reset = 1'b0;

        // Seat0 natural, seat1 ties the dealer at 17.
        served = 0; deck = {10, 9, 7, 1, 8, 10};
        start_round("t1", 4, 3);
        wait_state(S_PLAYER_TURN, 1, "t1 seat1 turn");
        check("t1 results clear", 32'(o_seatResult), 32'd0);
        pulse_stand();
        wait_done(req_seen);
        check("t1 seat0 sum", 32'(o_seatSum[4:0]), 32'd21);
        check("t1 seat1 sum", 32'(o_seatSum[9:5]), 32'd17);
        check("t1 dealer sum", 32'(o_dealerSum), 32'd17);
        check("t1 cards", 32'(served), 32'd6);

        // Dealer blackjack skips every seat turn.
        served = 0; deck = {1, 9, 1, 12, 9, 13};
        start_round("t2", 3, 2);
        wait_state(S_CHECK_DEALER_BJ, 2, "t2 check");
        check("t2 results cleared", 32'(o_seatResult), 32'd0);
        @(negedge i_clk);
        check("t2 straight to settle", 32'(o_gameState), 32'(S_SETTLE));
        wait_done(req_seen);

        // Five-card charlie on 11 beats a dealer 20.
        served = 0; deck = {2, 10, 10, 2, 10, 6, 3, 2, 2, 4};
        start_round("t3", 5, 3);
        for (int k = 0; k < 3; k++) begin
            wait_state(S_PLAYER_TURN, 0, "t3 seat0 turn");
            pulse_hit();
        end
        wait_state(S_PLAYER_TURN, 1, "t3 seat1 turn");
        pulse_stand();
        wait_done(req_seen);
        check("t3 seat0 sum", 32'(o_seatSum[4:0]), 32'd11);
        check("t3 dealer sum", 32'(o_dealerSum), 32'd20);
        check("t3 cards", 32'(served), 32'd10);

        // Both seats bust; dealer on 15 must not draw.
        served = 0; deck = {10, 10, 10, 6, 6, 5, 13, 13};
        start_round("t4", 2, 2);
        wait_state(S_PLAYER_TURN, 0, "t4 seat0 turn");
        pulse_hit();
        wait_state(S_PLAYER_TURN, 1, "t4 seat1 turn");
        pulse_hit();
        wait_state(S_DEALER_TURN, 2, "t4 dealer turn");
        wait_done(req_seen);
        check("t4 dealer req", 32'(req_seen), 32'd0);
        check("t4 cards", 32'(served), 32'd8);
        check("t4 seat0 sum", 32'(o_seatSum[4:0]), 32'd26);

        // Dealer soft 17 (A+6).
        served = 0; deck = {10, 10, 1, 9, 8, 6};
`ifdef DEALER_HITS_SOFT17_EN
        deck.push_back(10);
`endif
        start_round("t5", 1, 1);
        wait_state(S_PLAYER_TURN, 0, "t5 seat0 turn");
        pulse_stand();
        wait_state(S_PLAYER_TURN, 1, "t5 seat1 turn");
        pulse_stand();
        wait_done(req_seen);
        check("t5 dealer sum", 32'(o_dealerSum), 32'd17);
`ifdef DEALER_HITS_SOFT17_EN
        check("t5 cards", 32'(served), 32'd7);
`else
        check("t5 cards", 32'(served), 32'd6);
`endif

        // Deck stalls 10 cycles on the first card, then a reset lands mid-deal.
        served = 0; deck = {5, 4, 3, 2}; stall_left = 10; held = 0;
        @(negedge i_clk);
        i_newRound = 1'b1;
        @(negedge i_clk);
        i_newRound = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge i_clk);
            #1;
            if (i_cardValid) break;
            if (o_cardReq) held++;
        end
        check("t6 req held", 32'(held), 32'd10);
        check("t6 one card", 32'(served), 32'd1);
        wait_state(S_DEAL_WAIT, 2, "t6 dealer card");
        check("t6 seat0 sum", 32'(o_seatSum[4:0]), 32'd5);
        check("t6 seat1 sum", 32'(o_seatSum[9:5]), 32'd4);
        i_reset = 1'b1;
        @(negedge i_clk);
        check("t6 rst state", 32'(o_gameState), 32'(S_IDLE));
        check("t6 rst req", 32'(o_cardReq), 32'd0);
        check("t6 rst seat", 32'(o_activeSeat), 32'd0);
        check("t6 rst sums", 32'({o_seatSum, o_dealerSum}), 32'd0);
        check("t6 rst results", 32'({o_seatResult, o_roundDone}), 32'd0);
        i_reset = 1'b0;
        deck.delete();
        stall_left = 0;
        repeat (2) @(negedge i_clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
